pipe_mux_n: RTL and testbench

Parametrised N-way select with a configurable-depth registered output, used on datapath select points in the pipelined processor (operand forwarding, writeback source, next-PC source) where the selected value must cross a pipeline boundary. It generalises the plain 4-input combinational select to any input count and width. It adds a valid bit, stall (hold) and flush (kill) control matching the hazard unit's signalling, and out-of-range select detection.

---
 rtl/pipe_mux_n.sv | 87 ++++++++
 tb/tb_pipe_mux_n.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N-way select feeding STAGES registered pipeline stages.
// Each stage carries {valid, err, data}. The whole pipe holds on stall and
// clears on flush. A sticky flag records any out-of-range select accepted.
module pipe_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN),
  parameter int STAGES = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        select,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        output_value,
  output logic                    out_valid,
  output logic                    sel_error,
  output logic                    sel_error_sticky
);

  // True when the select index names an existing input.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] s);
    return (32'(s) < NUM_IN);
  endfunction

  logic             in_range;
  logic [WIDTH-1:0] data_mux;
  logic             vld_p0;
  logic             err_p0;
  logic [WIDTH-1:0] data_p0;

  // Index i holds pipeline stage i+1; the last entry drives the outputs.
  logic             vld_p  [STAGES];
  logic             err_p  [STAGES];
  logic [WIDTH-1:0] data_p [STAGES];

  // ---- Stage 0: combinational select ----
  // Decode the select; an unmatched index leaves the mux value at zero.
  always_comb begin
    data_mux = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (select == SEL_W'(k)) data_mux = data_in[k*WIDTH +: WIDTH];
    end
  end

  assign in_range = sel_in_range(select);
  assign vld_p0   = in_valid;
  assign err_p0   = in_valid & ~in_range;
  assign data_p0  = in_valid ? data_mux : '0;

  // ---- Stages 1..STAGES: registered shift with hold and kill ----
  // Reset and flush clear every stage; stall freezes; otherwise shift by one.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i]  <= 1'b0;
        err_p[i]  <= 1'b0;
        data_p[i] <= '0;
      end
    end else if (!stall) begin
      vld_p[0]  <= vld_p0;
      err_p[0]  <= err_p0;
      data_p[0] <= data_p0;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i]  <= vld_p[i-1];
        err_p[i]  <= err_p[i-1];
        data_p[i] <= data_p[i-1];
      end
    end
  end

  // Sticky error: set only when a bad-select beat actually enters stage 1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_error_sticky <= 1'b0;
    end else if (!flush && !stall && err_p0) begin
      sel_error_sticky <= 1'b1;
    end
  end

  assign output_value = data_p[STAGES-1];
  assign out_valid    = vld_p[STAGES-1];
  assign sel_error    = err_p[STAGES-1];

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed and randomised bench for pipe_mux_n across three configurations.
module tb_pipe_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  // Config A: WIDTH=32, NUM_IN=4, STAGES=1
  logic         a_valid, a_stall, a_flush;
  logic [1:0]   a_sel;
  logic [127:0] a_data;
  logic [31:0]  a_out;
  logic         a_ov, a_err, a_sticky;

  // Config B: WIDTH=32, NUM_IN=5, STAGES=3
  logic         b_valid, b_stall, b_flush;
  logic [2:0]   b_sel;
  logic [159:0] b_data;
  logic [31:0]  b_out;
  logic         b_ov, b_err, b_sticky;

  // Config C: WIDTH=8, NUM_IN=3, STAGES=2
  logic         c_valid, c_stall, c_flush;
  logic [1:0]   c_sel;
  logic [23:0]  c_data;
  logic [7:0]   c_out;
  logic         c_ov, c_err, c_sticky;

  logic [31:0] bv [5];

  pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .STAGES(1)) u_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .select(a_sel),
    .data_in(a_data), .stall(a_stall), .flush(a_flush),
    .output_value(a_out), .out_valid(a_ov), .sel_error(a_err),
    .sel_error_sticky(a_sticky));

  pipe_mux_n #(.WIDTH(32), .NUM_IN(5), .STAGES(3)) u_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .select(b_sel),
    .data_in(b_data), .stall(b_stall), .flush(b_flush),
    .output_value(b_out), .out_valid(b_ov), .sel_error(b_err),
    .sel_error_sticky(b_sticky));

  pipe_mux_n #(.WIDTH(8), .NUM_IN(3), .STAGES(2)) u_c (
    .clk(clk), .reset_n(reset_n), .in_valid(c_valid), .select(c_sel),
    .data_in(c_data), .stall(c_stall), .flush(c_flush),
    .output_value(c_out), .out_valid(c_ov), .sel_error(c_err),
    .sel_error_sticky(c_sticky));

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_out, a_ov, a_err, a_sticky} !== 35'h0) begin
      errors++;
      $display("FAIL reset_a got out=%h vld=%b err=%b sticky=%b want all 0", a_out, a_ov, a_err, a_sticky);
    end
    checks++;
    if ({b_out, b_ov, b_err, b_sticky} !== 35'h0) begin
      errors++;
      $display("FAIL reset_b got out=%h vld=%b err=%b sticky=%b want all 0", b_out, b_ov, b_err, b_sticky);
    end
    checks++;
    if ({c_out, c_ov, c_err, c_sticky} !== 11'h0) begin
      errors++;
      $display("FAIL reset_c got out=%h vld=%b err=%b sticky=%b want all 0", c_out, c_ov, c_err, c_sticky);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] exp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (a_out !== exp[k-1] || a_ov !== 1'b1 || a_err !== 1'b0) begin
          errors++;
          $display("FAIL basic_sel%0d got out=%h vld=%b err=%b want out=%h vld=1 err=0",
                   k-1, a_out, a_ov, a_err, exp[k-1]);
        end
      end
      if (k < 4) begin
        a_valid = 1'b1;
        a_sel   = 2'(k);
      end else begin
        a_valid = 1'b0;
        a_sel   = 2'd0;
      end
    end
    @(negedge clk);
    checks++;
    if (a_out !== 32'h0 || a_ov !== 1'b0 || a_sticky !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got out=%h vld=%b sticky=%b want out=0 vld=0 sticky=0", a_out, a_ov, a_sticky);
    end
  endtask

  task automatic test_out_of_range();
    // Out-of-range select with in_valid=0 must not touch any flag.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b_valid = 1'b0;
      b_sel   = 3'd7;
      if (k > 0) begin
        checks++;
        if (b_sticky !== 1'b0 || b_ov !== 1'b0 || b_err !== 1'b0) begin
          errors++;
          $display("FAIL oor_invalid%0d got sticky=%b vld=%b err=%b want 0 0 0", k, b_sticky, b_ov, b_err);
        end
      end
    end
    @(negedge clk);
    b_valid = 1'b1;
    b_sel   = 3'd7;
    @(negedge clk);
    b_valid = 1'b0;
    b_sel   = 3'd0;
    checks++;
    if (b_sticky !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky_set got %b want 1", b_sticky);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (b_out !== 32'h0 || b_ov !== 1'b1 || b_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_beat got out=%h vld=%b err=%b want out=0 vld=1 err=1", b_out, b_ov, b_err);
    end
    // Highest legal index of a non-power-of-two mux.
    b_valid = 1'b1;
    b_sel   = 3'd4;
    @(negedge clk);
    b_valid = 1'b0;
    b_sel   = 3'd0;
    checks++;
    if (b_ov !== 1'b0 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_after got vld=%b err=%b want 0 0", b_ov, b_err);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (b_out !== bv[4] || b_ov !== 1'b1 || b_err !== 1'b0) begin
      errors++;
      $display("FAIL sel4_beat got out=%h vld=%b err=%b want out=%h vld=1 err=0", b_out, b_ov, b_err, bv[4]);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if (b_sticky !== 1'b1) begin
        errors++;
        $display("FAIL oor_sticky_hold cycle %0d got %b want 1", k, b_sticky);
      end
    end
  endtask

  task automatic test_stall();
    // Beats A..D use selects 0..3; stall for two cycles once B is in.
    logic       dv   [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] ds   [10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    logic       dst  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       eov  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ev  [10];
    ev = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, bv[0], bv[1], bv[2], bv[3], 32'h0};
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n >= 1) begin
        checks++;
        if (b_out !== ev[n] || b_ov !== eov[n] || b_err !== 1'b0) begin
          errors++;
          $display("FAIL stall_cycle%0d got out=%h vld=%b err=%b want out=%h vld=%b err=0",
                   n, b_out, b_ov, b_err, ev[n], eov[n]);
        end
      end
      b_valid = dv[n];
      b_sel   = ds[n];
      b_stall = dst[n];
    end
    b_valid = 1'b0;
    b_stall = 1'b0;
  endtask

  task automatic test_flush();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_sel   = 3'(n);
    end
    @(negedge clk);
    checks++;
    if (b_out !== bv[0] || b_ov !== 1'b1) begin
      errors++;
      $display("FAIL flush_prefill got out=%h vld=%b want out=%h vld=1", b_out, b_ov, bv[0]);
    end
    b_valid = 1'b1;
    b_sel   = 3'd3;
    b_flush = 1'b1;
    b_stall = 1'b1;
    @(negedge clk);
    b_flush = 1'b0;
    b_stall = 1'b0;
    checks++;
    if (b_sticky !== 1'b1) begin
      errors++;
      $display("FAIL flush_keeps_sticky got %b want 1", b_sticky);
    end
    b_valid = 1'b1;
    b_sel   = 3'd4;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if (b_out !== 32'h0 || b_ov !== 1'b0 || b_err !== 1'b0) begin
        errors++;
        $display("FAIL flush_bubble%0d got out=%h vld=%b err=%b want 0 0 0", n, b_out, b_ov, b_err);
      end
      if (n == 0) begin
        @(negedge clk);
        b_valid = 1'b0;
        b_sel   = 3'd0;
        n++;
        checks++;
        if (b_out !== 32'h0 || b_ov !== 1'b0) begin
          errors++;
          $display("FAIL flush_bubble%0d got out=%h vld=%b want 0 0", n, b_out, b_ov);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (b_out !== bv[4] || b_ov !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_beat got out=%h vld=%b want out=%h vld=1", b_out, b_ov, bv[4]);
    end
    @(negedge clk);
    checks++;
    if (b_ov !== 1'b0 || b_out !== 32'h0) begin
      errors++;
      $display("FAIL flush_tail got out=%h vld=%b want 0 0", b_out, b_ov);
    end
  endtask

  task automatic test_reset_midstream();
    c_data = {8'hC3, 8'hB2, 8'hA1};
    @(negedge clk);
    c_valid = 1'b1;
    c_sel   = 2'd3;
    @(negedge clk);
    checks++;
    if (c_ov !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill got vld=%b want 0", c_ov);
    end
    c_sel = 2'd0;
    @(negedge clk);
    checks++;
    if (c_out !== 8'h00 || c_ov !== 1'b1 || c_err !== 1'b1 || c_sticky !== 1'b1) begin
      errors++;
      $display("FAIL mid_oor got out=%h vld=%b err=%b sticky=%b want 00 1 1 1", c_out, c_ov, c_err, c_sticky);
    end
    c_sel = 2'd1;
    @(negedge clk);
    checks++;
    if (c_out !== 8'hA1 || c_ov !== 1'b1 || c_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_beatA got out=%h vld=%b err=%b want a1 1 0", c_out, c_ov, c_err);
    end
    reset_n = 1'b0;
    c_sel   = 2'd2;
    @(negedge clk);
    reset_n = 1'b1;
    c_valid = 1'b0;
    c_sel   = 2'd0;
    checks++;
    if (c_out !== 8'h00 || c_ov !== 1'b0 || c_err !== 1'b0 || c_sticky !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got out=%h vld=%b err=%b sticky=%b want all 0", c_out, c_ov, c_err, c_sticky);
    end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checks++;
      if (c_out !== 8'h00 || c_ov !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_stale%0d got out=%h vld=%b want 0 0", n, c_out, c_ov);
      end
    end
  endtask

  task automatic test_random();
    logic       m_v  [2] = '{1'b0, 1'b0};
    logic       m_e  [2] = '{1'b0, 1'b0};
    logic [7:0] m_d  [2] = '{8'h0, 8'h0};
    logic       m_st = 1'b0;
    logic       v, st, fl, oor;
    logic [1:0] s;
    logic [23:0] d;
    logic [7:0] md;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      checks++;
      if ({c_ov, c_err, c_sticky, c_out} !== {m_v[1], m_e[1], m_st, m_d[1]}) begin
        errors++;
        $display("FAIL random cycle %0d got vld=%b err=%b sticky=%b out=%h want vld=%b err=%b sticky=%b out=%h",
                 cyc, c_ov, c_err, c_sticky, c_out, m_v[1], m_e[1], m_st, m_d[1]);
      end
      v  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      d  = 24'($urandom);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 15) == 0);
      c_valid = v;
      c_sel   = s;
      c_data  = d;
      c_stall = st;
      c_flush = fl;
      case (s)
        2'd0:    md = d[7:0];
        2'd1:    md = d[15:8];
        2'd2:    md = d[23:16];
        default: md = 8'h00;
      endcase
      oor = (s == 2'd3);
      if (fl) begin
        m_v = '{1'b0, 1'b0};
        m_e = '{1'b0, 1'b0};
        m_d = '{8'h0, 8'h0};
      end else if (!st) begin
        m_v[1] = m_v[0];
        m_e[1] = m_e[0];
        m_d[1] = m_d[0];
        m_v[0] = v;
        m_e[0] = v & oor;
        m_d[0] = v ? md : 8'h00;
        if (v && oor) m_st = 1'b1;
      end
    end
    @(negedge clk);
    c_valid = 1'b0;
    c_stall = 1'b0;
    c_flush = 1'b0;
  endtask

  initial begin
    bv = '{32'h0A0A0A0A, 32'h1B1B1B1B, 32'h2C2C2C2C, 32'h3D3D3D3D, 32'h4E4E4E4E};
    reset_n = 1'b0;
    a_valid = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_sel = '0;
    a_data  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    b_valid = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_sel = '0;
    b_data  = {bv[4], bv[3], bv[2], bv[1], bv[0]};
    c_valid = 1'b0; c_stall = 1'b0; c_flush = 1'b0; c_sel = '0;
    c_data  = '0;

    test_reset();
    test_basic();
    test_out_of_range();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
